// File: rtl/spi_reg_seq_if.sv
// Command, response and spi_master byte-stream bundle for spi_reg_seq.
// slave is the sequencer's view; master is the host / SPI-side view.
interface spi_reg_seq_if #(
  parameter int DATA_BYTES = 1,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_wr_i;
  logic [ADDR_W-1:0]       cmd_addr_i;
  logic [8*DATA_BYTES-1:0] cmd_data_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [8*DATA_BYTES-1:0] rsp_data_o;
  logic                    rsp_lost_o;
  logic                    spi_di_req_i;
  logic [7:0]              spi_di_o;
  logic                    spi_wren_o;
  logic                    spi_wr_ack_i;
  logic                    spi_do_valid_i;
  logic [7:0]              spi_do_i;
  logic                    busy_o;
  logic [LVL_W-1:0]        level_o;

  modport slave (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
           spi_di_req_i, spi_wr_ack_i, spi_do_valid_i, spi_do_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_lost_o,
           spi_di_o, spi_wren_o, busy_o, level_o
  );

  modport master (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
           spi_di_req_i, spi_wr_ack_i, spi_do_valid_i, spi_do_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_lost_o,
           spi_di_o, spi_wren_o, busy_o, level_o
  );
endinterface

// File: rtl/spi_reg_seq.sv
// Queues register read/write commands and streams each one as a byte frame
// to an spi_master, collecting read data from the returned byte stream.
module spi_reg_seq #(
  parameter int         DATA_BYTES = 1,
  parameter int         ADDR_W     = 7,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] CMD_BYTE   = 8'h89
) (
  input  logic          pclk_i,
  input  logic          rst_i,
  spi_reg_seq_if.slave  bus
);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int EW    = 1 + ADDR_W + DW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(2 + DATA_BYTES);
  localparam logic [IDX_W-1:0] LEN  = IDX_W'(3 + DATA_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [LVL_W-1:0] r_level;

  state_t           r_state;
  logic             r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]    r_data;
  logic [IDX_W-1:0] r_txIdx;
  logic [IDX_W-1:0] r_rxCnt;
  logic             r_reqDly;
  logic             r_wren;
  logic [7:0]       r_di;
  logic             r_busy;
  logic [DW-1:0]    r_shift;
  logic [DW-1:0]    r_rspData;
  logic             r_rspValid;
  logic             r_lost;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_rxStrobe;
  logic             w_rxData;
  logic [7:0]       w_txByte;
  logic [EW-1:0]    w_head;

  // Full is judged on the registered level, so a pop this cycle never frees a slot early.
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push     = bus.cmd_valid_i && !w_full;
  assign w_pop      = (r_state == LOAD);
  assign w_head     = r_mem[r_rdPtr];
  assign w_rxStrobe = bus.spi_do_valid_i && (r_state == SEND || r_state == DRAIN) && (r_rxCnt != LEN);
  assign w_rxData   = (r_rxCnt >= IDX_W'(2)) && (r_rxCnt <= IDX_W'(1 + DATA_BYTES));

  always_ff @(posedge pclk_i) begin
    if (w_push) r_mem[r_wrPtr] <= {bus.cmd_wr_i, bus.cmd_addr_i, bus.cmd_data_i};
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Byte at the current frame index; read frames send zero in the data slots.
  always_comb begin
    w_txByte = 8'h00;
    if (r_txIdx == '0) w_txByte = CMD_BYTE;
    if (r_txIdx == IDX_W'(1)) w_txByte = {r_wr, 7'(r_addr)};
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (r_txIdx == IDX_W'(2 + b)) w_txByte = r_wr ? r_data[8*(DATA_BYTES-1-b) +: 8] : 8'h00;
    end
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_txIdx    <= '0;
      r_rxCnt    <= '0;
      r_reqDly   <= 1'b0;
      r_wren     <= 1'b0;
      r_di       <= 8'h00;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_rspData  <= '0;
      r_rspValid <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_reqDly <= bus.spi_di_req_i;
      if (r_rspValid && bus.rsp_ready_i) r_rspValid <= 1'b0;
      if (w_rxStrobe) begin
        r_rxCnt <= r_rxCnt + 1'b1;
        if (w_rxData) r_shift <= DW'({r_shift, bus.spi_do_i});
      end
      case (r_state)
        IDLE: begin
          if (r_level != '0) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          {r_wr, r_addr, r_data} <= w_head;
          r_txIdx <= '0;
          r_rxCnt <= '0;
          r_state <= SEND;
        end
        SEND: begin
          if (r_wren) begin
            if (bus.spi_wr_ack_i) begin
              r_wren <= 1'b0;
              if (r_txIdx == LAST) r_state <= DRAIN;
              else r_txIdx <= r_txIdx + 1'b1;
            end
          end else if (bus.spi_di_req_i && !r_reqDly) begin
            r_wren <= 1'b1;
            r_di   <= w_txByte;
          end
        end
        DRAIN: begin
          // A completion that meets an unconsumed response keeps the old data.
          if (r_rxCnt == LEN) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (!r_wr) begin
              if (r_rspValid && !bus.rsp_ready_i) begin
                r_lost <= 1'b1;
              end else begin
                r_rspValid <= 1'b1;
                r_rspData  <= r_shift;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = !w_full;
  assign bus.level_o     = r_level;
  assign bus.busy_o      = r_busy;
  assign bus.spi_wren_o  = r_wren;
  assign bus.spi_di_o    = r_di;
  assign bus.rsp_valid_o = r_rspValid;
  assign bus.rsp_data_o  = r_rspData;
  assign bus.rsp_lost_o  = r_lost;
endmodule

// File: tb/tb_spi_reg_seq.sv
// Directed and randomized bench for spi_reg_seq: a bench-side SPI byte slave
// drives frames while whole-frame and response models supply expected values.
module tb_spi_reg_seq;
  localparam int DB = 2;
  localparam int AW = 7;
  localparam int FD = 8;
  localparam int L  = 3 + DB;
  localparam int DW = 8 * DB;
  localparam int FW = 8 * L;

  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

  logic          mRspValid = 1'b0;
  logic [DW-1:0] mRspData = '0;
  logic          mLost = 1'b0;

  logic          qWr [9];
  logic [6:0]    qAddr [9];
  logic [DW-1:0] qData [9];

  always #5 clk = ~clk;

  spi_reg_seq_if #(.DATA_BYTES(DB), .ADDR_W(AW), .FIFO_DEPTH(FD)) bus ();

  spi_reg_seq #(
    .DATA_BYTES(DB),
    .ADDR_W(AW),
    .FIFO_DEPTH(FD),
    .CMD_BYTE(8'h89)
  ) dut (
    .pclk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole frame as one concatenation; pick byte i counting from the front.
  function automatic logic [7:0] expByte(input logic wr, input logic [6:0] addr,
                                         input logic [DW-1:0] data, input int i);
    logic [FW-1:0] frame;
    frame = {8'h89, wr, addr, (wr ? data : DW'(0)), 8'h00};
    return frame[8*(L-1-i) +: 8];
  endfunction

  task automatic applyStimulus(input logic wr, input logic [6:0] addr, input logic [DW-1:0] data);
    int n;
    n = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_wr_i    = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    while (!bus.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic waitBusy();
    int n;
    n = 0;
    while (!bus.busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busyRise", bus.busy_o, 1);
    @(negedge clk);
  endtask

  task automatic doByte(input int ackDly, input logic [7:0] rx, output logic [7:0] tx);
    int n;
    logic stable;
    n = 0;
    bus.spi_di_req_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.spi_wren_o && n < 20);
    checkOutput("wrenLatency", n, 1);
    tx = bus.spi_di_o;
    stable = 1'b1;
    for (int k = 0; k < ackDly; k++) begin
      @(negedge clk);
      if (bus.spi_wren_o !== 1'b1 || bus.spi_di_o !== tx) stable = 1'b0;
    end
    if (ackDly > 0) checkOutput("wrenStable", stable, 1);
    bus.spi_wr_ack_i = 1'b1;
    @(negedge clk);
    bus.spi_wr_ack_i = 1'b0;
    bus.spi_di_req_i = 1'b0;
    checkOutput("wrenDrop", bus.spi_wren_o, 0);
    bus.spi_do_valid_i = 1'b1;
    bus.spi_do_i = rx;
    @(negedge clk);
    bus.spi_do_valid_i = 1'b0;
  endtask

  task automatic runFrame(input string tag, input logic wr, input logic [6:0] addr,
                          input logic [DW-1:0] data, input int ackDly, input logic [FW-1:0] rxIn);
    logic [7:0] rx [L];
    logic [7:0] tx;
    int n;
    waitBusy();
    for (int i = 0; i < L; i++) begin
      rx[i] = rxIn[8*(L-1-i) +: 8];
      doByte(ackDly, rx[i], tx);
      checkOutput($sformatf("%s_tx%0d", tag, i), tx, expByte(wr, addr, data, i));
    end
    n = 0;
    while (bus.busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, bus.busy_o, 0);
    if (!wr) begin
      if (mRspValid) begin
        mLost = 1'b1;
      end else begin
        mRspValid = 1'b1;
        for (int b = 0; b < DB; b++) mRspData[8*(DB-1-b) +: 8] = rx[2+b];
      end
    end
    checkOutput({tag, "_rspValid"}, bus.rsp_valid_o, mRspValid);
    checkOutput({tag, "_rspData"}, bus.rsp_data_o, mRspData);
    checkOutput({tag, "_lost"}, bus.rsp_lost_o, mLost);
  endtask

  task automatic popRsp();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    mRspValid = 1'b0;
    checkOutput("rspClear", bus.rsp_valid_o, 0);
  endtask

  initial begin
    logic          w;
    logic [6:0]    a;
    logic [DW-1:0] d;
    logic [FW-1:0] rxv;
    logic [7:0]    tx;
    int            n;

    bus.cmd_valid_i    = 1'b0;
    bus.cmd_wr_i       = 1'b0;
    bus.cmd_addr_i     = '0;
    bus.cmd_data_i     = '0;
    bus.rsp_ready_i    = 1'b0;
    bus.spi_di_req_i   = 1'b0;
    bus.spi_wr_ack_i   = 1'b0;
    bus.spi_do_valid_i = 1'b0;
    bus.spi_do_i       = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("rstLevel", bus.level_o, 0);
    checkOutput("rstReady", bus.cmd_ready_o, 1);
    checkOutput("rstRspValid", bus.rsp_valid_o, 0);
    checkOutput("rstRspData", bus.rsp_data_o, 0);
    checkOutput("rstLost", bus.rsp_lost_o, 0);
    checkOutput("rstWren", bus.spi_wren_o, 0);
    checkOutput("rstDi", bus.spi_di_o, 0);
    checkOutput("rstBusy", bus.busy_o, 0);

    // SPI activity while idle must not start anything
    for (int k = 0; k < 3; k++) begin
      bus.spi_di_req_i = 1'b1;
      @(negedge clk);
      bus.spi_di_req_i = 1'b0;
      bus.spi_do_valid_i = 1'b1;
      bus.spi_do_i = 8'hFF;
      @(negedge clk);
      bus.spi_do_valid_i = 1'b0;
    end
    checkOutput("idleWren", bus.spi_wren_o, 0);
    checkOutput("idleBusy", bus.busy_o, 0);

    applyStimulus(1'b1, 7'h24, 16'h0000);
    runFrame("wr24", 1'b1, 7'h24, 16'h0000, 0, FW'({$urandom(), $urandom()}));

    applyStimulus(1'b0, 7'h05, 16'hBEEF);
    runFrame("rd05", 1'b0, 7'h05, 16'hBEEF, 2, {8'h5A, 8'hC3, 8'h12, 8'h34, 8'h7E});
    checkOutput("rd05Model", mRspData, 16'h1234);
    repeat (4) @(negedge clk);
    checkOutput("rd05HoldV", bus.rsp_valid_o, 1);
    checkOutput("rd05HoldD", bus.rsp_data_o, 16'h1234);
    popRsp();

    d = DW'($urandom());
    applyStimulus(1'b1, 7'h6B, d);
    runFrame("ack5", 1'b1, 7'h6B, d, 5, FW'({$urandom(), $urandom()}));

    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom());
      a = 7'($urandom());
      d = DW'($urandom());
      applyStimulus(w, a, d);
      runFrame($sformatf("rand%0d", i), w, a, d, int'($urandom_range(0, 3)),
               FW'({$urandom(), $urandom()}));
      if (!w) popRsp();
    end

    applyStimulus(1'b0, 7'h0A, 16'h0);
    applyStimulus(1'b0, 7'h0B, 16'h0);
    runFrame("lost1", 1'b0, 7'h0A, 16'h0, 1, FW'({$urandom(), $urandom()}));
    runFrame("lost2", 1'b0, 7'h0B, 16'h0, 0, FW'({$urandom(), $urandom()}));
    popRsp();
    checkOutput("lostSticky", bus.rsp_lost_o, 1);

    // Stall one frame mid-send while the queue fills behind it
    applyStimulus(1'b1, 7'h40, 16'h1111);
    waitBusy();
    for (int i = 0; i < 8; i++) begin
      qWr[i]   = 1'($urandom());
      qAddr[i] = 7'($urandom());
      qData[i] = DW'($urandom());
      applyStimulus(qWr[i], qAddr[i], qData[i]);
    end
    checkOutput("fillLevel", bus.level_o, 8);
    checkOutput("fillReady", bus.cmd_ready_o, 0);
    qWr[8]   = 1'b1;
    qAddr[8] = 7'h7F;
    qData[8] = DW'($urandom());
    bus.cmd_valid_i = 1'b1;
    bus.cmd_wr_i    = qWr[8];
    bus.cmd_addr_i  = qAddr[8];
    bus.cmd_data_i  = qData[8];
    repeat (3) @(negedge clk);
    checkOutput("fillHeld", bus.level_o, 8);
    runFrame("fillA", 1'b1, 7'h40, 16'h1111, 0, FW'({$urandom(), $urandom()}));
    checkOutput("fillHeldEnd", bus.cmd_ready_o, 0);
    n = 0;
    while (!bus.cmd_ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fillAdmit", bus.cmd_ready_o, 1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    checkOutput("fillRefill", bus.level_o, 8);
    for (int i = 0; i < 9; i++) begin
      runFrame($sformatf("fill%0d", i), qWr[i], qAddr[i], qData[i], i % 3,
               FW'({$urandom(), $urandom()}));
      if (!qWr[i]) popRsp();
    end
    checkOutput("fillEmpty", bus.level_o, 0);

    // Reset in the middle of data byte index 2 of a write
    applyStimulus(1'b1, 7'h11, 16'hA5A5);
    applyStimulus(1'b1, 7'h22, 16'h5A5A);
    waitBusy();
    doByte(0, 8'h00, tx);
    checkOutput("abortB0", tx, 8'h89);
    doByte(0, 8'h00, tx);
    checkOutput("abortB1", tx, 8'h91);
    bus.spi_di_req_i = 1'b1;
    @(negedge clk);
    checkOutput("abortB2Wren", bus.spi_wren_o, 1);
    checkOutput("abortB2Di", bus.spi_di_o, 8'hA5);
    rst = 1'b1;
    #1;
    checkOutput("abortWren", bus.spi_wren_o, 0);
    checkOutput("abortLevel", bus.level_o, 0);
    checkOutput("abortBusy", bus.busy_o, 0);
    checkOutput("abortDi", bus.spi_di_o, 0);
    checkOutput("abortLost", bus.rsp_lost_o, 0);
    @(negedge clk);
    bus.spi_di_req_i = 1'b0;
    rst = 1'b0;
    mRspValid = 1'b0;
    mRspData  = '0;
    mLost     = 1'b0;
    @(negedge clk);
    checkOutput("postRstBusy", bus.busy_o, 0);
    checkOutput("postRstRsp", bus.rsp_valid_o, 0);
    applyStimulus(1'b1, 7'h33, 16'h0F0F);
    runFrame("postRst", 1'b1, 7'h33, 16'h0F0F, 1, FW'({$urandom(), $urandom()}));
    checkOutput("postRstLevel", bus.level_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_reg_seq.md
SPI_REG_SEQ -- requirements
Module: spi_reg_seq

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 1, data bytes per register access (1..4).
REQ-002 SHALL have parameter ADDR_W, default 7, register address width (1..7).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, command queue entries (power of two, >=2).
REQ-004 SHALL have parameter CMD_BYTE, default 8'h89, frame header byte.
REQ-005 SHALL have ports, in order: pclk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid_i in 1 command offered.
REQ-007 SHALL have port cmd_ready_o out 1 queue can accept.
REQ-008 SHALL have port cmd_wr_i in 1 access type: 1 write, 0 read.
REQ-009 SHALL have port cmd_addr_i in ADDR_W register address.
REQ-010 SHALL have port cmd_data_i in 8*DATA_BYTES write data.
REQ-011 SHALL have port rsp_valid_o out 1 read data available.
REQ-012 SHALL have port rsp_ready_i in 1 read data consumed.
REQ-013 SHALL have port rsp_data_o out 8*DATA_BYTES read data.
REQ-014 SHALL have port rsp_lost_o out 1 sticky flag: a read response was dropped.
REQ-015 SHALL have port spi_di_req_i in 1 spi_master requests the next TX byte.
REQ-016 SHALL have port spi_di_o out 8 TX byte to spi_master.
REQ-017 SHALL have port spi_wren_o out 1 TX byte valid.
REQ-018 SHALL have port spi_wr_ack_i in 1 spi_master accepted the byte.
REQ-019 SHALL have port spi_do_valid_i in 1 RX byte strobe.
REQ-020 SHALL have port spi_do_i in 8 RX byte.
REQ-021 SHALL have port busy_o out 1 frame in progress.
REQ-022 SHALL have port level_o out $clog2(FIFO_DEPTH)+1 queue occupancy.

Function
REQ-023 SHALL push {cmd_wr_i, cmd_addr_i, cmd_data_i} on a cycle where cmd_valid_i && cmd_ready_o; cmd_ready_o = queue not full at cycle start, so a same-cycle pop SHALL NOT admit a push when full.
REQ-024 SHALL send each queued command as a frame of L = 3+DATA_BYTES bytes: CMD_BYTE; {cmd_wr, zero-extended addr to 7 bits}; DATA_BYTES bytes MSB first (write: data; read: 8'h00); trailer 8'h00.
REQ-025 SHALL use states IDLE -> LOAD (pop queue, 1 cycle) -> SEND (byte index 0..L-1) -> DRAIN (await remaining RX strobes) -> IDLE; IDLE with empty queue stays IDLE.
REQ-026 SHALL detect a rising edge of spi_di_req_i (registered compare); on the cycle after the edge present the current byte on spi_di_o and raise spi_wren_o.
REQ-027 SHALL hold spi_di_o stable and spi_wren_o high until spi_wr_ack_i is sampled high, then drop spi_wren_o next cycle and advance the byte index; spi_wren_o SHALL be low in IDLE, LOAD, DRAIN.
REQ-028 SHALL count spi_do_valid_i pulses per frame from 0; for reads, RX bytes with index 2..1+DATA_BYTES SHALL be shifted into rsp_data_o MSB first.
REQ-029 SHALL leave DRAIN when L RX strobes have been counted; busy_o high in LOAD, SEND, DRAIN.
REQ-030 SHALL, at the end of a read frame, set rsp_valid_o and hold rsp_data_o until rsp_valid_o && rsp_ready_i clears it; write frames SHALL produce no response.
REQ-031 SHALL, if a read completes while rsp_valid_o is high and rsp_ready_i low, keep old data and set rsp_lost_o until reset; completion with rsp_ready_i high in the same cycle SHALL replace the data with no loss.
REQ-032 SHALL ignore spi_di_req_i edges and spi_do_valid_i pulses while IDLE.
REQ-033 SHALL update level_o as +1 on push, -1 on pop, unchanged on simultaneous push/pop.

Reset
REQ-034 SHALL, on rst_i high, asynchronously clear: queue (level_o=0), state IDLE, cmd_ready_o=1 after release, rsp_valid_o=0, rsp_data_o=0, rsp_lost_o=0, spi_wren_o=0, spi_di_o=8'h00, busy_o=0.
REQ-035 SHALL abandon any frame in progress on reset; no partial response.

Verification
REQ-036 Write, DATA_BYTES=1: addr 7'h24 data 8'h00 -> bytes 89,A4,00,00 on wren/ack handshakes; no rsp_valid_o.
REQ-037 Read, DATA_BYTES=2: addr 7'h05, slave returns xx,xx,12,34,xx -> TX 89,05,00,00,00; rsp_data_o=16'h1234 held until rsp_ready_i.
REQ-038 Push 9 commands back-to-back with SPI stalled, FIFO_DEPTH=8 -> cmd_ready_o low after 8th push (level_o=8), 9th held off until first pop.
REQ-039 Two reads, rsp_ready_i tied low -> first data retained, rsp_lost_o=1 after second frame.
REQ-040 Assert rst_i during byte index 2 of a write -> spi_wren_o=0, level_o=0, busy_o=0 immediately; next command frame starts at CMD_BYTE.
REQ-041 Delayed spi_wr_ack_i (5 cycles) -> spi_di_o and spi_wren_o stable throughout; no duplicate or skipped byte.
